// File: rtl/fwd_scoreboard_pkg.sv
// Shared widths and helpers for the operand bypass / pending-write scoreboard.
// Optional statistics outputs are enabled by defining FWD_SCOREBOARD_STATS_EN.
package fwd_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam int WARP_SIZE      = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int STAT_W         = 32;

  // fwd_src code for "operand comes from the register file"
  localparam int FWD_SRC_RF     = 0;

  typedef logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] warp_data_t;

  // fwd_src needs one code for RF plus one per bypass stage
  function automatic int fwd_src_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Pending counter must hold 0..max_pending inclusive
  function automatic int cnt_w(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_pending_scoreboard.sv
// Per-warp, per-register pending-write counters for long-latency ops.
// Owns issue/complete/flush updates, issue back-pressure, the sticky
// underflow flag and NUM_SRC combinational read ports for decode.
module pending_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_SRC     = 3,
  parameter int MAX_PENDING = 3,
  localparam int WID        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PW         = cnt_w(MAX_PENDING)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_iss_valid,
  input  logic [WID-1:0]                         i_iss_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0]              i_iss_rd,
  input  logic                                   i_cmp_valid,
  input  logic [WID-1:0]                         i_cmp_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0]              i_cmp_rd,
  input  logic                                   i_flush_valid,
  input  logic [WID-1:0]                         i_flush_warp_id,
  input  logic [WID-1:0]                         i_rd_warp_id,
  input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] i_rd_reg,
  output logic [NUM_SRC-1:0][PW-1:0]             o_rd_cnt,
  output logic                                   o_iss_ready,
  output logic                                   o_err_underflow
);

  logic [PW-1:0] r_cnt     [NUM_WARPS][NUM_REGS];
  logic [PW-1:0] w_cnt_nxt [NUM_WARPS][NUM_REGS];
  logic          r_err_underflow;
  logic          w_underflow;
  logic          w_flush_iss;
  logic          w_flush_cmp;
  logic          w_iss_live;
  logic          w_cmp_live;
  logic          w_same_entry;

  assign o_err_underflow = r_err_underflow;

  // Issue allowed while below the limit; x0 never accumulates a count
  assign o_iss_ready = (i_iss_rd == '0) ||
                       (r_cnt[i_iss_warp_id][i_iss_rd] < PW'(MAX_PENDING));

  // Qualify events: a same-warp flush discards a complete and frees room for an issue
  always_comb begin
    w_flush_iss  = i_flush_valid && (i_flush_warp_id == i_iss_warp_id);
    w_flush_cmp  = i_flush_valid && (i_flush_warp_id == i_cmp_warp_id);
    w_iss_live   = i_iss_valid && (i_iss_rd != '0) && (o_iss_ready || w_flush_iss);
    w_cmp_live   = i_cmp_valid && (i_cmp_rd != '0) && !w_flush_cmp;
    w_same_entry = w_iss_live && w_cmp_live &&
                   (i_iss_warp_id == i_cmp_warp_id) && (i_iss_rd == i_cmp_rd);
  end

  // Next counter state: flush first, then issue/complete; matching pair cancels
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_underflow = 1'b0;
    if (i_flush_valid) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        w_cnt_nxt[i_flush_warp_id][r] = '0;
      end
    end
    if (!w_same_entry) begin
      if (w_iss_live) begin
        w_cnt_nxt[i_iss_warp_id][i_iss_rd] = w_cnt_nxt[i_iss_warp_id][i_iss_rd] + PW'(1);
      end
      if (w_cmp_live) begin
        if (r_cnt[i_cmp_warp_id][i_cmp_rd] == '0) begin
          w_underflow = 1'b1;
        end else begin
          w_cnt_nxt[i_cmp_warp_id][i_cmp_rd] = w_cnt_nxt[i_cmp_warp_id][i_cmp_rd] - PW'(1);
        end
      end
    end
  end

  // Counter storage and sticky underflow, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_cnt[w][r] <= '0;
        end
      end
      r_err_underflow <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_underflow) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // Decode-side read ports see current state only
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      o_rd_cnt[s] = r_cnt[i_rd_warp_id][i_rd_reg[s]];
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand bypass with pending-write scoreboard for the SIMT decode stage.
// Priority forwarding mux (youngest stage wins) plus decode stall generation.
// Define FWD_SCOREBOARD_STATS_EN to add saturating statistics outputs.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_SRC     = 3,
  parameter int NUM_STAGES  = 3,
  parameter int MAX_PENDING = 3,
  localparam int WID        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PW         = cnt_w(MAX_PENDING),
  localparam int SW         = fwd_src_w(NUM_STAGES)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      dec_valid,
  input  logic [WID-1:0]                            dec_warp_id,
  input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]    dec_rs,
  input  logic [NUM_SRC-1:0]                        dec_rs_used,
  input  warp_data_t [NUM_SRC-1:0]                  rf_data,
  input  logic [NUM_STAGES-1:0]                     stg_valid,
  input  logic [NUM_STAGES-1:0]                     stg_reg_write,
  input  logic [NUM_STAGES-1:0]                     stg_ready,
  input  logic [NUM_STAGES-1:0][WID-1:0]            stg_warp_id,
  input  logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0] stg_rd,
  input  warp_data_t [NUM_STAGES-1:0]               stg_result,
  input  logic                                      iss_valid,
  input  logic [WID-1:0]                            iss_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0]                 iss_rd,
  input  logic                                      cmp_valid,
  input  logic [WID-1:0]                            cmp_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0]                 cmp_rd,
  input  logic                                      flush_valid,
  input  logic [WID-1:0]                            flush_warp_id,
  output warp_data_t [NUM_SRC-1:0]                  fwd_data,
  output logic [NUM_SRC-1:0][SW-1:0]                fwd_src,
  output logic                                      dec_stall,
  output logic                                      iss_ready,
  output logic                                      err_underflow
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [NUM_STAGES-1:0][STAT_W-1:0]         stat_fwd_hits,
  output logic [STAT_W-1:0]                         stat_stall_cycles,
  output logic [STAT_W-1:0]                         stat_issue_blocked
`endif
);

  logic [NUM_SRC-1:0][PW-1:0] w_rd_cnt;
  logic [NUM_SRC-1:0]         w_win_ready;
  logic                       w_stall_any;

  pending_scoreboard #(
    .NUM_WARPS   (NUM_WARPS),
    .NUM_SRC     (NUM_SRC),
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_iss_valid     (iss_valid),
    .i_iss_warp_id   (iss_warp_id),
    .i_iss_rd        (iss_rd),
    .i_cmp_valid     (cmp_valid),
    .i_cmp_warp_id   (cmp_warp_id),
    .i_cmp_rd        (cmp_rd),
    .i_flush_valid   (flush_valid),
    .i_flush_warp_id (flush_warp_id),
    .i_rd_warp_id    (dec_warp_id),
    .i_rd_reg        (dec_rs),
    .o_rd_cnt        (w_rd_cnt),
    .o_iss_ready     (iss_ready),
    .o_err_underflow (err_underflow)
  );

  // Priority mux: scan oldest to youngest so the lowest matching stage is left standing
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_src[s]     = SW'(FWD_SRC_RF);
      fwd_data[s]    = rf_data[s];
      w_win_ready[s] = 1'b1;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (stg_valid[k] && stg_reg_write[k] && (stg_warp_id[k] == dec_warp_id) &&
            (stg_rd[k] == dec_rs[s]) && (dec_rs[s] != '0)) begin
          fwd_src[s]     = SW'(k + 1);
          fwd_data[s]    = stg_result[k];
          w_win_ready[s] = stg_ready[k];
        end
      end
    end
  end

  // Stall if any used source is pending or its winning stage has no result yet
  always_comb begin
    w_stall_any = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (dec_rs_used[s] && ((w_rd_cnt[s] != '0) || !w_win_ready[s])) begin
        w_stall_any = 1'b1;
      end
    end
    dec_stall = dec_valid && w_stall_any;
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  localparam int HW = $clog2(NUM_SRC + 1);

  logic [NUM_STAGES-1:0][HW-1:0] w_hit_inc;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

  // Count forwarded used sources per stage for accepted decodes
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_hit_inc[k] = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (dec_valid && !dec_stall && dec_rs_used[s] && (fwd_src[s] == SW'(k + 1))) begin
          w_hit_inc[k] = w_hit_inc[k] + HW'(1);
        end
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fwd_hits      <= '0;
      stat_stall_cycles  <= '0;
      stat_issue_blocked <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stat_fwd_hits[k] <= sat_add(stat_fwd_hits[k], STAT_W'(w_hit_inc[k]));
      end
      if (dec_stall) begin
        stat_stall_cycles <= sat_add(stat_stall_cycles, STAT_W'(1));
      end
      if (iss_valid && !iss_ready) begin
        stat_issue_blocked <= sat_add(stat_issue_blocked, STAT_W'(1));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized
// traffic compared against a behavioural model of forwarding and pending counts.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int NW  = 4;
  localparam int NS  = 3;
  localparam int NST = 3;
  localparam int MP  = 3;
  localparam int WID = 2;
  localparam int SW  = fwd_src_w(NST);
  localparam int RA  = REG_ADDR_WIDTH;

  logic                      clk;
  logic                      rst;
  logic                      dec_valid;
  logic [WID-1:0]            dec_warp_id;
  logic [NS-1:0][RA-1:0]     dec_rs;
  logic [NS-1:0]             dec_rs_used;
  warp_data_t [NS-1:0]       rf_data;
  logic [NST-1:0]            stg_valid;
  logic [NST-1:0]            stg_reg_write;
  logic [NST-1:0]            stg_ready;
  logic [NST-1:0][WID-1:0]   stg_warp_id;
  logic [NST-1:0][RA-1:0]    stg_rd;
  warp_data_t [NST-1:0]      stg_result;
  logic                      iss_valid;
  logic [WID-1:0]            iss_warp_id;
  logic [RA-1:0]             iss_rd;
  logic                      cmp_valid;
  logic [WID-1:0]            cmp_warp_id;
  logic [RA-1:0]             cmp_rd;
  logic                      flush_valid;
  logic [WID-1:0]            flush_warp_id;
  warp_data_t [NS-1:0]       fwd_data;
  logic [NS-1:0][SW-1:0]     fwd_src;
  logic                      dec_stall;
  logic                      iss_ready;
  logic                      err_underflow;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [NST-1:0][STAT_W-1:0] stat_fwd_hits;
  logic [STAT_W-1:0]          stat_stall_cycles;
  logic [STAT_W-1:0]          stat_issue_blocked;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: pending writes per (warp, register) and sticky underflow
  int m_cnt [NW][NUM_REGS];
  bit m_uf;

  fwd_scoreboard #(
    .NUM_WARPS(NW), .NUM_SRC(NS), .NUM_STAGES(NST), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_warp_id(dec_warp_id), .dec_rs(dec_rs),
    .dec_rs_used(dec_rs_used), .rf_data(rf_data),
    .stg_valid(stg_valid), .stg_reg_write(stg_reg_write), .stg_ready(stg_ready),
    .stg_warp_id(stg_warp_id), .stg_rd(stg_rd), .stg_result(stg_result),
    .iss_valid(iss_valid), .iss_warp_id(iss_warp_id), .iss_rd(iss_rd),
    .cmp_valid(cmp_valid), .cmp_warp_id(cmp_warp_id), .cmp_rd(cmp_rd),
    .flush_valid(flush_valid), .flush_warp_id(flush_warp_id),
    .fwd_data(fwd_data), .fwd_src(fwd_src), .dec_stall(dec_stall),
    .iss_ready(iss_ready), .err_underflow(err_underflow)
`ifdef FWD_SCOREBOARD_STATS_EN
    , .stat_fwd_hits(stat_fwd_hits), .stat_stall_cycles(stat_stall_cycles),
    .stat_issue_blocked(stat_issue_blocked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int exp_src(int s);
    for (int k = 0; k < NST; k++) begin
      if (stg_valid[k] && stg_reg_write[k] && stg_warp_id[k] == dec_warp_id &&
          stg_rd[k] == dec_rs[s] && dec_rs[s] != 0) return k + 1;
    end
    return 0;
  endfunction

  function automatic warp_data_t exp_data(int s);
    int k = exp_src(s);
    return (k == 0) ? rf_data[s] : stg_result[k-1];
  endfunction

  function automatic bit exp_stall();
    if (!dec_valid) return 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (dec_rs_used[s]) begin
        int k = exp_src(s);
        if (m_cnt[int'(dec_warp_id)][int'(dec_rs[s])] > 0) return 1'b1;
        if (k != 0 && !stg_ready[k-1]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit exp_iss_ready();
    return (iss_rd == 0) || (m_cnt[int'(iss_warp_id)][int'(iss_rd)] < MP);
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NUM_REGS; r++) m_cnt[w][r] = 0;
    m_uf = 1'b0;
  endfunction

  // Applies one clock edge worth of issue/complete/flush rules to the model
  function automatic void model_step();
    int  iw = int'(iss_warp_id), ir = int'(iss_rd);
    int  cw = int'(cmp_warp_id), cr = int'(cmp_rd);
    int  old_c = m_cnt[cw][cr];
    bit  fl_i  = flush_valid && flush_warp_id == iss_warp_id;
    bit  fl_c  = flush_valid && flush_warp_id == cmp_warp_id;
    bit  iss_ok = iss_valid && ir != 0 && (fl_i || m_cnt[iw][ir] < MP);
    bit  cmp_ok = cmp_valid && cr != 0 && !fl_c;
    if (flush_valid)
      for (int r = 0; r < NUM_REGS; r++) m_cnt[int'(flush_warp_id)][r] = 0;
    if (iss_ok && cmp_ok && iw == cw && ir == cr) return;
    if (iss_ok) m_cnt[iw][ir] = m_cnt[iw][ir] + 1;
    if (cmp_ok) begin
      if (old_c == 0) m_uf = 1'b1;
      else m_cnt[cw][cr] = m_cnt[cw][cr] - 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    dec_valid = 0; dec_warp_id = '0; dec_rs = '0; dec_rs_used = '0; rf_data = '0;
    stg_valid = '0; stg_reg_write = '0; stg_ready = '0; stg_warp_id = '0;
    stg_rd = '0; stg_result = '0;
    iss_valid = 0; iss_warp_id = '0; iss_rd = '0;
    cmp_valid = 0; cmp_warp_id = '0; cmp_rd = '0;
    flush_valid = 0; flush_warp_id = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic decode_one(input int w, input int r);
    dec_valid = 1; dec_warp_id = WID'(w); dec_rs = '0; dec_rs_used = '0;
    dec_rs[0] = RA'(r); dec_rs_used[0] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%0b exp=1", iss_ready); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL reset_dec_stall got=%0b exp=0", dec_stall); end
    checks++; if (fwd_src !== '0) begin failures++; $display("FAIL reset_fwd_src got=%0h exp=0", fwd_src); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%0b exp=0", err_underflow); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    idle();
    decode_one(0, 10);
    for (int s = 0; s < NS; s++) for (int l = 0; l < WARP_SIZE; l++) rf_data[s][l] = $urandom();
    for (int k = 0; k < NST; k++) begin
      stg_valid[k] = 1; stg_reg_write[k] = 1; stg_ready[k] = 1;
      stg_warp_id[k] = '0; stg_rd[k] = RA'(10);
      for (int l = 0; l < WARP_SIZE; l++) stg_result[k][l] = $urandom();
    end
    for (int step = 0; step <= NST; step++) begin
      #1;
      checks++; if (fwd_src[0] !== SW'((step + 1) % (NST + 1))) begin failures++;
        $display("FAIL prio_src step=%0d got=%0d exp=%0d", step, fwd_src[0], (step + 1) % (NST + 1)); end
      checks++; if (fwd_data[0] !== ((step < NST) ? stg_result[step] : rf_data[0])) begin failures++;
        $display("FAIL prio_data step=%0d got=%h", step, fwd_data[0]); end
      checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL prio_stall step=%0d got=%0b exp=0", step, dec_stall); end
      if (step < NST) stg_valid[step] = 1'b0;
    end
  endtask

  task automatic test_not_ready();
    idle();
    decode_one(0, 10);
    for (int k = 0; k < 2; k++) begin
      stg_valid[k] = 1; stg_reg_write[k] = 1; stg_warp_id[k] = '0; stg_rd[k] = RA'(10);
      for (int l = 0; l < WARP_SIZE; l++) stg_result[k][l] = $urandom();
    end
    stg_ready[0] = 0; stg_ready[1] = 1;
    #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL notready_stall got=%0b exp=1", dec_stall); end
    stg_ready[0] = 1;
    #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL ready_stall got=%0b exp=0", dec_stall); end
    checks++; if (fwd_src[0] !== SW'(1)) begin failures++; $display("FAIL ready_src got=%0d exp=1", fwd_src[0]); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_warp_id = WID'(1); iss_rd = RA'(7);
    for (int i = 0; i < MP; i++) begin
      #1;
      checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sb_iss_ready_%0d got=%0b exp=1", i, iss_ready); end
      tick();
    end
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sb_full got=%0b exp=0", iss_ready); end
    iss_valid = 0;
    decode_one(1, 7);
    #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_full got=%0b exp=1", dec_stall); end
    for (int i = 0; i < MP; i++) begin
      cmp_valid = 1; cmp_warp_id = WID'(1); cmp_rd = RA'(7);
      tick();
      cmp_valid = 0;
      #1;
      checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_after_cmp%0d got=%0b exp=1", i, iss_ready); end
      checks++; if (dec_stall !== (i < MP - 1)) begin failures++;
        $display("FAIL sb_stall_after_cmp%0d got=%0b exp=%0b", i, dec_stall, i < MP - 1); end
    end
  endtask

  task automatic test_flush();
    idle();
    iss_valid = 1; iss_warp_id = WID'(2); iss_rd = RA'(3);
    tick(); tick();
    iss_warp_id = WID'(3);
    tick();
    iss_valid = 1; iss_warp_id = WID'(2); iss_rd = RA'(3);
    flush_valid = 1; flush_warp_id = WID'(2);
    tick();
    idle();
    decode_one(2, 3); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL flush_issue_cnt1 got=%0b exp=1", dec_stall); end
    decode_one(3, 3); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL flush_other_warp got=%0b exp=1", dec_stall); end
    cmp_valid = 1; cmp_warp_id = WID'(2); cmp_rd = RA'(3);
    tick();
    cmp_valid = 0;
    decode_one(2, 3); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL flush_cnt_zero got=%0b exp=0", dec_stall); end
    cmp_valid = 1; flush_valid = 1; flush_warp_id = WID'(2);
    tick();
    cmp_valid = 0; flush_valid = 0; #1;
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL flush_cmp_no_uf got=%0b exp=0", err_underflow); end
    cmp_valid = 1; cmp_warp_id = WID'(3);
    tick();
    cmp_valid = 0;
    decode_one(3, 3); #1;
    checks++; if (dec_stall !== 1'b0 || err_underflow !== 1'b0) begin failures++;
      $display("FAIL flush_w3_drain got stall=%0b uf=%0b exp 0/0", dec_stall, err_underflow); end
  endtask

  task automatic test_simultaneous();
    idle();
    iss_valid = 1; iss_warp_id = '0; iss_rd = RA'(5);
    tick();
    cmp_valid = 1; cmp_warp_id = '0; cmp_rd = RA'(5);
    tick();
    iss_valid = 0; cmp_valid = 0;
    decode_one(0, 5); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL simul_cnt_kept got=%0b exp=1", dec_stall); end
    cmp_valid = 1;
    tick();
    cmp_valid = 0; #1;
    checks++; if (dec_stall !== 1'b0 || err_underflow !== 1'b0) begin failures++;
      $display("FAIL simul_drain got stall=%0b uf=%0b exp 0/0", dec_stall, err_underflow); end
    cmp_valid = 1;
    tick();
    cmp_valid = 0; #1;
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%0b exp=1", err_underflow); end
    tick();
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%0b exp=1", err_underflow); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL underflow_cnt_zero got=%0b exp=0", dec_stall); end
  endtask

  task automatic test_x0_reset();
    idle();
    iss_valid = 1; iss_warp_id = '0; iss_rd = '0; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL x0_iss_ready got=%0b exp=1", iss_ready); end
    tick();
    iss_valid = 0;
    decode_one(0, 0);
    stg_valid[0] = 1; stg_reg_write[0] = 1; stg_ready[0] = 0; stg_warp_id[0] = '0; stg_rd[0] = '0;
    #1;
    checks++; if (fwd_src[0] !== '0) begin failures++; $display("FAIL x0_src got=%0d exp=0", fwd_src[0]); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0b exp=0", dec_stall); end
    stg_valid = '0;
    iss_valid = 1; iss_warp_id = WID'(1); iss_rd = RA'(9);
    tick(); tick(); tick();
    iss_valid = 0;
    decode_one(1, 9); #1;
    checks++; if (dec_stall !== 1'b1 || iss_ready !== 1'b0) begin failures++;
      $display("FAIL prerst got stall=%0b ready=%0b exp 1/0", dec_stall, iss_ready); end
    @(negedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL rst_async_stall got=%0b exp=0", dec_stall); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%0b exp=1", iss_ready); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rst_async_uf got=%0b exp=0", err_underflow); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL rst_no_replay got=%0b exp=0", dec_stall); end
  endtask

  task automatic randomize_inputs();
    dec_valid   = ($urandom_range(0, 3) != 0);
    dec_warp_id = WID'($urandom_range(0, NW - 1));
    for (int s = 0; s < NS; s++) begin
      dec_rs[s]      = RA'($urandom_range(0, 7));
      dec_rs_used[s] = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < WARP_SIZE; l++) rf_data[s][l] = $urandom();
    end
    for (int k = 0; k < NST; k++) begin
      stg_valid[k]     = $urandom_range(0, 1) == 1;
      stg_reg_write[k] = ($urandom_range(0, 3) != 0);
      stg_ready[k]     = ($urandom_range(0, 3) != 0);
      stg_warp_id[k]   = ($urandom_range(0, 1) == 1) ? dec_warp_id : WID'($urandom_range(0, NW - 1));
      stg_rd[k]        = RA'($urandom_range(0, 7));
      for (int l = 0; l < WARP_SIZE; l++) stg_result[k][l] = $urandom();
    end
    iss_valid     = $urandom_range(0, 1) == 1;
    iss_warp_id   = WID'($urandom_range(0, NW - 1));
    iss_rd        = RA'($urandom_range(0, 7));
    cmp_valid     = ($urandom_range(0, 3) == 0);
    cmp_warp_id   = WID'($urandom_range(0, NW - 1));
    cmp_rd        = RA'($urandom_range(1, 7));
    flush_valid   = ($urandom_range(0, 15) == 0);
    flush_warp_id = WID'($urandom_range(0, NW - 1));
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      randomize_inputs();
      #1;
      for (int s = 0; s < NS; s++) begin
        checks++; if (fwd_src[s] !== SW'(exp_src(s))) begin failures++;
          $display("FAIL rnd_src cyc=%0d s=%0d got=%0d exp=%0d", cyc, s, fwd_src[s], exp_src(s)); end
        checks++; if (fwd_data[s] !== exp_data(s)) begin failures++;
          $display("FAIL rnd_data cyc=%0d s=%0d got=%h exp=%h", cyc, s, fwd_data[s], exp_data(s)); end
      end
      checks++; if (dec_stall !== exp_stall()) begin failures++;
        $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, dec_stall, exp_stall()); end
      checks++; if (iss_ready !== exp_iss_ready()) begin failures++;
        $display("FAIL rnd_iss_ready cyc=%0d got=%0b exp=%0b", cyc, iss_ready, exp_iss_ready()); end
      checks++; if (err_underflow !== m_uf) begin failures++;
        $display("FAIL rnd_underflow cyc=%0d got=%0b exp=%0b", cyc, err_underflow, m_uf); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_not_ready();
    test_scoreboard();
    test_flush();
    test_simultaneous();
    test_x0_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
